// File: rtl/wptr_full_prog_if.sv
// wptr_full_prog_if: write-client/status bundle of the write-domain FIFO pointer block
interface wptr_full_prog_if #(parameter int ADDR_LINES = 8);
  logic                  winc;
  logic [ADDR_LINES:0]   wq2_rptr;
  logic [ADDR_LINES:0]   af_thresh;
  logic                  wovf_clr;
  logic [ADDR_LINES-1:0] waddr;
  logic [ADDR_LINES:0]   wptr;
  logic                  wfull;
  logic                  walmost_full;
  logic                  whalf_full;
  logic [ADDR_LINES:0]   wlevel;
  logic                  woverflow;
  logic [15:0]           wdrop_cnt;
  modport master (
    output winc, wq2_rptr, af_thresh, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, whalf_full, wlevel, woverflow, wdrop_cnt
  );
  modport slave (
    input  winc, wq2_rptr, af_thresh, wovf_clr,
    output waddr, wptr, wfull, walmost_full, whalf_full, wlevel, woverflow, wdrop_cnt
  );
endinterface

// File: rtl/wptr_full_prog.sv
// wptr_full_prog: write pointer, fill level and status flags of a dual-clock FIFO (optional WPTR_FULL_DROP_CNT_EN)
module wptr_full_prog #(
  parameter int ADDR_LINES = 8
) (
  input logic               wclk,
  input logic               wrst,
  wptr_full_prog_if.slave   bus
);
  localparam int A = ADDR_LINES;
  localparam logic [A:0] HALF = {1'b0, 1'b1, {(A-1){1'b0}}};
  logic [A:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin_s;
  logic       wfull_q, wfull_d, waf_q, waf_d, whf_q, whf_d, wovf_q, wovf_d, wr, drop;
  assign wr       = bus.winc & ~wfull_q;
  assign drop     = bus.winc & wfull_q;
  assign wbin_d   = wbin_q + {{A{1'b0}}, wr};
  assign wptr_d   = (wbin_d >> 1) ^ wbin_d;
  assign wlevel_d = wbin_d - rbin_s;
  assign wfull_d  = wptr_d == {~bus.wq2_rptr[A:A-1], bus.wq2_rptr[A-2:0]};
  assign waf_d    = (bus.af_thresh != '0) && (wlevel_d >= bus.af_thresh);
  assign whf_d    = wlevel_d >= HALF;
  assign wovf_d   = drop | (wovf_q & ~bus.wovf_clr);
  // Gray-to-binary of the synchronised read pointer
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= A; i++) rbin_s[i] = ^(bus.wq2_rptr >> i);
  end
  // pointer and status registers; flags reflect the post-write state of each edge
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      whf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      whf_q    <= whf_d;
      wovf_q   <= wovf_d;
    end
  end
  assign bus.waddr        = wbin_q[A-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = waf_q;
  assign bus.whalf_full   = whf_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.woverflow    = wovf_q;
`ifdef WPTR_FULL_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;
  assign drop_d = bus.wovf_clr ? {15'd0, drop} : (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  // saturating dropped-write counter; a drop in the clearing cycle still counts
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) drop_q <= '0;
    else drop_q <= drop_d;
  end
  assign bus.wdrop_cnt = drop_q;
`else
  assign bus.wdrop_cnt = '0;
`endif
endmodule

// File: tb/tb_wptr_full_prog.sv
// tb_wptr_full_prog: table vectors plus scoreboarded sequences for wptr_full_prog (ADDR_LINES=4)
module tb_wptr_full_prog;
  localparam int A = 4;
`ifdef WPTR_FULL_DROP_CNT_EN
  localparam bit DROP_ON = 1'b1;
`else
  localparam bit DROP_ON = 1'b0;
`endif
  typedef struct {
    logic [3:0]  waddr;
    logic [4:0]  wptr;
    logic [4:0]  wlevel;
    logic        full;
    logic        af;
    logic        hf;
    logic        ovf;
    logic [15:0] drop;
  } exp_t;
  typedef struct {
    logic       winc;
    logic [4:0] rbin;
    logic [4:0] thr;
    logic       clr;
    exp_t       e;
  } vec_t;
  logic wclk = 1'b0;
  logic wrst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  vec_t tbl[23];
  exp_t sbq[$];
  exp_t zero_e;
  int   m_w, m_drop;
  bit   m_full, m_ovf;
  wptr_full_prog_if #(.ADDR_LINES(A)) bus();
  wptr_full_prog #(.ADDR_LINES(A)) dut (.wclk(wclk), .wrst(wrst), .bus(bus.slave));
  always #5 wclk = ~wclk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  function automatic logic [4:0] gray(logic [4:0] b);
    return (b >> 1) ^ b;
  endfunction
  function void chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endfunction
  task automatic drive(logic winc, logic [4:0] rbin, logic [4:0] thr, logic clr);
    bus.winc = winc;
    bus.wq2_rptr = gray(rbin);
    bus.af_thresh = thr;
    bus.wovf_clr = clr;
  endtask
  task automatic compare(string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
      return;
    end
    e = sbq.pop_front();
    chk({tag, ".waddr"}, int'(bus.waddr), int'(e.waddr));
    chk({tag, ".wptr"}, int'(bus.wptr), int'(e.wptr));
    chk({tag, ".wlevel"}, int'(bus.wlevel), int'(e.wlevel));
    chk({tag, ".wfull"}, int'(bus.wfull), int'(e.full));
    chk({tag, ".walmost_full"}, int'(bus.walmost_full), int'(e.af));
    chk({tag, ".whalf_full"}, int'(bus.whalf_full), int'(e.hf));
    chk({tag, ".woverflow"}, int'(bus.woverflow), int'(e.ovf));
    chk({tag, ".wdrop_cnt"}, int'(bus.wdrop_cnt), int'(e.drop));
  endtask
  task automatic mstep(logic winc, int rb, int thr, logic clr, string tag);
    exp_t e;
    bit acc, dr;
    int lvl;
    acc = winc && !m_full;
    dr = winc && m_full;
    m_w = (m_w + int'(acc)) % 32;
    lvl = (m_w - rb + 32) % 32;
    m_drop = !DROP_ON ? 0 : clr ? int'(dr) : (m_drop + int'(dr) > 65535) ? 65535 : m_drop + int'(dr);
    m_ovf = dr || (m_ovf && !clr);
    m_full = lvl == 16;
    e.waddr = 4'(m_w);
    e.wptr = gray(5'(m_w));
    e.wlevel = 5'(lvl);
    e.full = m_full;
    e.af = thr != 0 && lvl >= thr;
    e.hf = lvl >= 8;
    e.ovf = m_ovf;
    e.drop = 16'(m_drop);
    drive(winc, 5'(rb), 5'(thr), clr);
    sbq.push_back(e);
    @(posedge wclk);
    #1;
    compare(tag);
  endtask
  task automatic do_reset(string tag);
    wrst = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    #1;
    sbq.push_back(zero_e);
    compare(tag);
    #10;
    wrst = 1'b1;
    m_w = 0; m_drop = 0; m_full = 1'b0; m_ovf = 1'b0;
  endtask
  initial begin
    zero_e = '{waddr: '0, wptr: '0, wlevel: '0, full: 1'b0, af: 1'b0, hf: 1'b0, ovf: 1'b0, drop: '0};
    for (int r = 0; r < 16; r++) begin
      tbl[r] = '{winc: 1'b1, rbin: 5'd0, thr: 5'd12, clr: 1'b0,
                 e: '{waddr: 4'(r + 1), wptr: gray(5'(r + 1)), wlevel: 5'(r + 1), full: r == 15,
                      af: r >= 11, hf: r >= 7, ovf: 1'b0, drop: '0}};
    end
    for (int r = 16; r < 19; r++) begin
      tbl[r] = '{winc: 1'b1, rbin: 5'd0, thr: 5'd12, clr: 1'b0,
                 e: '{waddr: 4'd0, wptr: 5'h18, wlevel: 5'd16, full: 1'b1, af: 1'b1, hf: 1'b1,
                      ovf: 1'b1, drop: DROP_ON ? 16'(r - 15) : 16'd0}};
    end
    tbl[19] = '{winc: 1'b0, rbin: 5'd0, thr: 5'd12, clr: 1'b1,
                e: '{waddr: 4'd0, wptr: 5'h18, wlevel: 5'd16, full: 1'b1, af: 1'b1, hf: 1'b1, ovf: 1'b0, drop: 16'd0}};
    tbl[20] = '{winc: 1'b1, rbin: 5'd0, thr: 5'd12, clr: 1'b1,
                e: '{waddr: 4'd0, wptr: 5'h18, wlevel: 5'd16, full: 1'b1, af: 1'b1, hf: 1'b1, ovf: 1'b1,
                     drop: DROP_ON ? 16'd1 : 16'd0}};
    tbl[21] = '{winc: 1'b0, rbin: 5'd0, thr: 5'd12, clr: 1'b1,
                e: '{waddr: 4'd0, wptr: 5'h18, wlevel: 5'd16, full: 1'b1, af: 1'b1, hf: 1'b1, ovf: 1'b0, drop: 16'd0}};
    tbl[22] = '{winc: 1'b0, rbin: 5'd4, thr: 5'd12, clr: 1'b0,
                e: '{waddr: 4'd0, wptr: 5'h18, wlevel: 5'd12, full: 1'b0, af: 1'b1, hf: 1'b1, ovf: 1'b0, drop: 16'd0}};
    drive(1'b0, 5'd0, 5'd0, 1'b0);
    #22;
    do_reset("reset0");
    @(posedge wclk);
    #1;
    for (int i = 0; i < 23; i++) begin
      drive(tbl[i].winc, tbl[i].rbin, tbl[i].thr, tbl[i].clr);
      sbq.push_back(tbl[i].e);
      @(posedge wclk);
      #1;
      compare($sformatf("vec%0d", i));
    end
    do_reset("reset1");
    for (int i = 0; i < 18; i++) mstep(1'b1, 0, 0, 1'b0, $sformatf("af_off%0d", i));
    mstep(1'b0, 0, 0, 1'b1, "af_off_clr");
    do_reset("reset2");
    for (int i = 0; i < 40; i++) mstep(1'b1, (i + 1 >= 4) ? (i - 3) % 32 : 0, 6, 1'b0, $sformatf("wrap%0d", i));
    do_reset("reset3");
    for (int i = 0; i < 9; i++) mstep(1'b1, 0, 0, 1'b0, $sformatf("burst%0d", i));
    #3;
    wrst = 1'b0;
    #1;
    sbq.push_back(zero_e);
    compare("async_rst");
    #2;
    wrst = 1'b1;
    m_w = 0; m_drop = 0; m_full = 1'b0; m_ovf = 1'b0;
    chk("waddr_after_rst", int'(bus.waddr), 0);
    mstep(1'b1, 0, 0, 1'b0, "first_after_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wptr_full_prog.md
# wptr_full_prog

Write-domain pointer and status controller for the dual-clock FIFO. It generalises the fixed write-pointer/full block with a depth parameter, a programmable almost-full threshold, a registered fill level, half-full derived from true occupancy, and a sticky overflow flag. It sits in the `wclk` domain between the write client and the FIFO memory. It consumes the two-flop-synchronised Gray read pointer and produces the Gray write pointer for the read-side synchroniser.

## Interface
- `ADDR_LINES`, 8, address width; FIFO depth is 2^ADDR_LINES (ADDR_LINES ≥ 2).
- `wclk`  in  1  write clock.
- `wrst`  in  1  reset: asynchronous, active-low.
- `winc`  in  1  write request; accepted only when `wfull`=0.
- `wq2_rptr`  in  ADDR_LINES+1  Gray read pointer, already synchronised into `wclk`.
- `af_thresh`  in  ADDR_LINES+1  almost-full threshold in words; quasi-static; 0 disables.
- `wovf_clr`  in  1  clears `woverflow` (single-cycle pulse).
- `waddr`  out  ADDR_LINES  memory write address (low bits of binary pointer).
- `wptr`  out  ADDR_LINES+1  registered Gray write pointer.
- `wfull`  out  1  FIFO full.
- `walmost_full`  out  1  level ≥ `af_thresh`.
- `whalf_full`  out  1  level ≥ 2^(ADDR_LINES-1).
- `wlevel`  out  ADDR_LINES+1  occupancy as seen from the write side, 0..2^ADDR_LINES.
- `woverflow`  out  1  sticky: a write was attempted while full.
- `wdrop_cnt`  out  16  dropped-write counter (see Configuration).

## Operation
- `wbin` is the (ADDR_LINES+1)-bit binary pointer.
  - `wbinnext` = `wbin` + (`winc` & ~`wfull`), modulo 2^(ADDR_LINES+1).
  - `wgraynext` = (`wbinnext`>>1) ^ `wbinnext`.
- `rbin_s` = Gray-to-binary of `wq2_rptr`: bit i = XOR of `wq2_rptr` bits [ADDR_LINES:i].
- `level_next` = `wbinnext` − `rbin_s`, modulo 2^(ADDR_LINES+1). This is always in 0..2^ADDR_LINES for legal inputs.
- Full condition: `wgraynext` == {~`wq2_rptr`[top two bits], `wq2_rptr`[rest]}. This is equivalent to `level_next` == 2^ADDR_LINES.
- Almost-full: (`af_thresh` != 0) && `level_next` ≥ `af_thresh`.
- Half-full: `level_next` ≥ 2^(ADDR_LINES-1).
- Overflow:
  - Set when `winc` & `wfull`.
  - Cleared by `wovf_clr`.
  - Set wins over clear in the same cycle.
- A write while full does not move any pointer or change `waddr`.
- `wfull`, `walmost_full`, `whalf_full` and `wlevel` are pessimistic. They deassert only after the read pointer propagates through the synchroniser. No read-side event can ever make them under-report.

## Timing
- Reset (`wrst`=0, asynchronous) forces these outputs to 0:
  - `wbin`, `wptr`, `waddr`
  - `wfull`, `walmost_full`, `whalf_full`
  - `wlevel`, `woverflow`, `wdrop_cnt`
- Reset takes effect immediately, mid-operation included; pointers return to 0 regardless of in-flight writes.
- All outputs are registered and update on the rising `wclk` edge.
- The status flags and `wlevel` reflect the state after any write accepted on that edge. The edge that accepts the Nth word shows `wlevel`=N, with no extra latency.
- `waddr` presents the slot for the current write; the memory writes at `waddr` when `winc` & ~`wfull`.
- Wrap-around: `wbin` rolls from 2^(ADDR_LINES+1)−1 to 0. The MSB toggle distinguishes full from empty. Level arithmetic is modular.
- A write and a read-pointer change in the same cycle both contribute to `level_next`. The net level is unchanged if both move by one.

## Configuration
- `WPTR_FULL_DROP_CNT_EN` defined:
  - `wdrop_cnt` increments on every `winc` & `wfull`.
  - It saturates at 0xFFFF.
  - It clears to 0 on `wovf_clr`. If a drop and `wovf_clr` occur in the same cycle, the result is 1.
- Undefined: `wdrop_cnt` is tied to 0 and no counter flops are built. `woverflow` is unaffected.

## Test plan
- ADDR_LINES=4, `wq2_rptr`=0, `af_thresh`=0: 16 consecutive writes → on the 16th edge `wfull`=1, `wptr`=0x18, `wlevel`=16, `waddr`=0; `whalf_full` rose on the 8th edge.
- Full, then `winc` held for 3 cycles → `wptr` stays 0x18, `woverflow`=1, `wdrop_cnt`=3 (macro on) or 0 (macro off). Then `wovf_clr` pulse → both 0.
- `af_thresh`=12: `walmost_full` first asserts on the edge accepting the 12th write. With `af_thresh`=0 it never asserts, even when full.
- Wrap: write 20 words while `wq2_rptr` follows Gray(`wbin`−4) → `wlevel` holds at 4 across the rollover, and `wfull` is never asserted.
- Simultaneous `winc` while full and `wovf_clr` → `woverflow`=1, `wdrop_cnt`=1.
- Assert `wrst` low mid-burst at `wlevel`=9, without waiting for a clock edge → all outputs 0 immediately; the first write after release uses `waddr`=0.
